// File: rtl/vmem_arbiter.sv
// vmem_arbiter
// Shares one single-port 64-bit video memory between a CPU port and an LCD
// refresh port. The LCD wins ties unless the CPU has already lost STARVE_MAX
// consecutive cycles. Read data comes back one cycle after the grant. A
// registered owner tag steers the rvalid strobe to the port that issued the read.
module vmem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [63:0]       cpu_wdata,
  input  logic [7:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [63:0]       cpu_rdata,
  output logic              cpu_rvalid,
  // LCD port
  input  logic              lcd_req,
  input  logic [ADDR_W-1:0] lcd_addr,
  output logic              lcd_ready,
  output logic [63:0]       lcd_rdata,
  output logic              lcd_rvalid,
  // Memory port
  output logic              mem_en,
  output logic [7:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_LCD  = 2'b10
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_e     owner_r;
  owner_e     owner_next_s;
  logic [3:0] starve_cnt_r;
  logic [3:0] starve_cnt_next_s;
  logic       cpu_force_s;
  logic       grant_lcd_s;
  logic       grant_cpu_s;

  // Pick at most one winner this cycle; nothing is granted while reset is low
  always_comb begin
    grant_lcd_s = 1'b0;
    grant_cpu_s = 1'b0;
    cpu_force_s = (starve_cnt_r == STARVE_LIM);
    if (!sys_rst) begin
      grant_lcd_s = 1'b0;
      grant_cpu_s = 1'b0;
    end else if (lcd_req && !(cpu_req && cpu_force_s)) begin
      grant_lcd_s = 1'b1;
    end else if (cpu_req) begin
      grant_cpu_s = 1'b1;
    end else begin
      grant_lcd_s = 1'b0;
      grant_cpu_s = 1'b0;
    end
  end

  // Drive the memory port and the ready handshakes from the winner
  always_comb begin
    cpu_ready = 1'b0;
    lcd_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 8'h00;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = 64'h0;
    if (grant_lcd_s) begin
      mem_en    = 1'b1;
      mem_addr  = lcd_addr;
      lcd_ready = 1'b1;
    end else if (grant_cpu_s) begin
      mem_en    = 1'b1;
      mem_addr  = cpu_addr;
      cpu_ready = 1'b1;
      if (cpu_we) begin
        // A zero strobe still takes the slot but changes no bytes
        mem_we    = cpu_wstrb;
        mem_wdata = cpu_wdata;
      end else begin
        mem_we    = 8'h00;
        mem_wdata = 64'h0;
      end
    end else begin
      mem_en    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
    end
  end

  // Next read-owner tag and CPU starvation count
  always_comb begin
    owner_next_s      = OWN_NONE;
    starve_cnt_next_s = starve_cnt_r;
    if (grant_lcd_s) begin
      owner_next_s = OWN_LCD;
    end else if (grant_cpu_s && !cpu_we) begin
      owner_next_s = OWN_CPU;
    end else begin
      owner_next_s = OWN_NONE;
    end
    if (!cpu_req || grant_cpu_s) begin
      starve_cnt_next_s = 4'd0;
    end else if (starve_cnt_r < STARVE_LIM) begin
      starve_cnt_next_s = starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
  end

  // State registers; reset drops any read return still in flight
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      owner_r      <= OWN_NONE;
      starve_cnt_r <= 4'd0;
    end else begin
      owner_r      <= owner_next_s;
      starve_cnt_r <= starve_cnt_next_s;
    end
  end

  // Decode the owner tag into one-cycle rvalid strobes
  always_comb begin
    cpu_rvalid = 1'b0;
    lcd_rvalid = 1'b0;
    case (owner_r)
      OWN_CPU:  cpu_rvalid = 1'b1;
      OWN_LCD:  lcd_rvalid = 1'b1;
      OWN_NONE: begin
        cpu_rvalid = 1'b0;
        lcd_rvalid = 1'b0;
      end
      default: begin
        cpu_rvalid = 1'b0;
        lcd_rvalid = 1'b0;
      end
    endcase
  end

  // Read data passes straight through; consumers qualify it with rvalid
  assign cpu_rdata = mem_rdata;
  assign lcd_rdata = mem_rdata;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Self-checking bench for vmem_arbiter: a behavioural memory plus a rule-level
// reference model (loss counter, shadow memory, expected read return).
module tb_vmem_arbiter;

  localparam int ADDR_W     = 10;
  localparam int STARVE_MAX = 4;

  logic              sys_clk;
  logic              sys_rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [63:0]       cpu_wdata;
  logic [7:0]        cpu_wstrb;
  logic              cpu_ready, cpu_rvalid;
  logic [63:0]       cpu_rdata;
  logic              lcd_req;
  logic [ADDR_W-1:0] lcd_addr;
  logic              lcd_ready, lcd_rvalid;
  logic [63:0]       lcd_rdata;
  logic              mem_en;
  logic [7:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  vmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_ready(lcd_ready),
    .lcd_rdata(lcd_rdata), .lcd_rvalid(lcd_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Behavioural synchronous RAM with byte enables and one-cycle read latency
  logic [63:0] ram [1024];
  always @(posedge sys_clk) begin
    if (mem_en) begin
      for (int b = 0; b < 8; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      if (mem_we == 8'h00) mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state
  logic [63:0] shadow [1024];
  int          losses;
  int          pend;        // 0 none, 1 cpu, 2 lcd
  logic [63:0] pend_data;
  bit          e_gl, e_gc, e_crv, e_lrv;
  logic [63:0] e_rdata;
  // Observations taken away from the clock edge
  logic        o_cpu_ready, o_lcd_ready, o_mem_en, o_cpu_rvalid, o_lcd_rvalid;
  logic [7:0]  o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [63:0] o_mem_wdata, o_cpu_rdata, o_lcd_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [63:0] init_word(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'(i) * 32'h9E37_79B1};
  endfunction

  // One clock: predict from spec rules, observe at negedge, advance model after the edge
  task automatic cycle();
    @(negedge sys_clk);
    e_crv   = sys_rst && (pend == 1);
    e_lrv   = sys_rst && (pend == 2);
    e_rdata = pend_data;
    e_gl    = 1'b0;
    e_gc    = 1'b0;
    if (sys_rst) begin
      if (lcd_req && !(cpu_req && losses == STARVE_MAX)) e_gl = 1'b1;
      else if (cpu_req) e_gc = 1'b1;
    end
    o_cpu_ready = cpu_ready;   o_lcd_ready = lcd_ready;
    o_mem_en = mem_en;         o_mem_we = mem_we;
    o_mem_addr = mem_addr;     o_mem_wdata = mem_wdata;
    o_cpu_rvalid = cpu_rvalid; o_lcd_rvalid = lcd_rvalid;
    o_cpu_rdata = cpu_rdata;   o_lcd_rdata = lcd_rdata;
    @(posedge sys_clk);
    #1;
    if (!sys_rst) begin
      losses = 0;
      pend   = 0;
    end else begin
      if (e_gl) begin
        pend = 2; pend_data = shadow[lcd_addr];
      end else if (e_gc && !cpu_we) begin
        pend = 1; pend_data = shadow[cpu_addr];
      end else begin
        pend = 0;
      end
      if (e_gc && cpu_we)
        for (int b = 0; b < 8; b++)
          if (cpu_wstrb[b]) shadow[cpu_addr][b*8 +: 8] = cpu_wdata[b*8 +: 8];
      if (!cpu_req || e_gc) losses = 0;
      else if (losses < STARVE_MAX) losses = losses + 1;
    end
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0; lcd_req = 1'b0; cpu_we = 1'b0; cpu_wstrb = 8'h00;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    sys_rst = 1'b0; cpu_req = 1'b1; lcd_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 10'h031; lcd_addr = 10'h030;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if ({o_cpu_ready, o_lcd_ready, o_mem_en, o_cpu_rvalid, o_lcd_rvalid, o_mem_we} !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got rdy=%b/%b en=%b rv=%b/%b we=%h, expected all 0",
                 o_cpu_ready, o_lcd_ready, o_mem_en, o_cpu_rvalid, o_lcd_rvalid, o_mem_we);
      end
    end
    sys_rst = 1'b1; cpu_req = 1'b0;
    cycle();
    n_checks++;
    if (o_lcd_ready !== 1'b1 || o_lcd_rvalid !== 1'b0 || o_mem_addr !== 10'h030) begin
      n_fail++;
      $display("FAIL first_grant_after_reset: got lcd_ready=%b lcd_rvalid=%b addr=%h, expected 1 0 030",
               o_lcd_ready, o_lcd_rvalid, o_mem_addr);
    end
    lcd_req = 1'b0;
    cycle();
    n_checks++;
    if (o_lcd_rvalid !== 1'b1 || o_lcd_rdata !== init_word(10'h030)) begin
      n_fail++;
      $display("FAIL first_read_return: got rvalid=%b data=%h, expected 1 %h",
               o_lcd_rvalid, o_lcd_rdata, init_word(10'h030));
    end
    idle(1);
  endtask

  task automatic test_lcd_burst();
    for (int k = 0; k < 6; k++) begin
      lcd_req  = (k < 4);
      lcd_addr = 10'h010 + 10'(k);
      cycle();
      if (k < 4) begin
        n_checks++;
        if (o_lcd_ready !== 1'b1 || o_mem_addr !== 10'h010 + 10'(k) || o_mem_we !== 8'h00) begin
          n_fail++;
          $display("FAIL lcd_burst_grant k=%0d: got ready=%b addr=%h we=%h, expected 1 %h 00",
                   k, o_lcd_ready, o_mem_addr, o_mem_we, 10'h010 + 10'(k));
        end
      end
      n_checks++;
      if (o_lcd_rvalid !== (k >= 1 && k <= 4) ||
          (k >= 1 && k <= 4 && o_lcd_rdata !== init_word(16'h010 + k - 1))) begin
        n_fail++;
        $display("FAIL lcd_burst_return k=%0d: got rvalid=%b data=%h, expected %b %h",
                 k, o_lcd_rvalid, o_lcd_rdata, (k >= 1 && k <= 4), init_word(16'h010 + k - 1));
      end
    end
    idle(1);
  endtask

  task automatic test_partial_write();
    logic [63:0] old_word, exp_word;
    old_word = init_word(10'h3FF);
    exp_word = {old_word[63:32], 32'h5566_7788};
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF;
    cpu_wdata = 64'h1122_3344_5566_7788; cpu_wstrb = 8'h0F;
    cycle();
    n_checks++;
    if (o_cpu_ready !== 1'b1 || o_mem_we !== 8'h0F || o_mem_wdata !== 64'h1122_3344_5566_7788 ||
        o_mem_addr !== 10'h3FF) begin
      n_fail++;
      $display("FAIL partial_write_grant: got ready=%b we=%h wdata=%h addr=%h, expected 1 0f 1122334455667788 3ff",
               o_cpu_ready, o_mem_we, o_mem_wdata, o_mem_addr);
    end
    cpu_we = 1'b0;
    cycle();
    n_checks++;
    if (o_cpu_ready !== 1'b1 || o_cpu_rvalid !== 1'b0 || o_mem_we !== 8'h00) begin
      n_fail++;
      $display("FAIL partial_read_grant: got ready=%b rvalid=%b we=%h, expected 1 0 00",
               o_cpu_ready, o_cpu_rvalid, o_mem_we);
    end
    cpu_req = 1'b0;
    cycle();
    n_checks++;
    if (o_cpu_rvalid !== 1'b1 || o_cpu_rdata !== exp_word) begin
      n_fail++;
      $display("FAIL partial_read_data: got rvalid=%b data=%h, expected 1 %h",
               o_cpu_rvalid, o_cpu_rdata, exp_word);
    end
    idle(1);
  endtask

  task automatic test_starvation();
    cpu_req = 1'b1; lcd_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 10'h041; lcd_addr = 10'h040;
    for (int k = 0; k < 10; k++) begin
      cycle();
      n_checks++;
      if (o_cpu_ready !== (k % 5 == 4) || o_lcd_ready !== (k % 5 != 4)) begin
        n_fail++;
        $display("FAIL starve_pattern k=%0d: got cpu=%b lcd=%b, expected cpu=%b lcd=%b",
                 k, o_cpu_ready, o_lcd_ready, (k % 5 == 4), (k % 5 != 4));
      end
    end
    cpu_req = 1'b0; lcd_req = 1'b0;
    cycle();
    n_checks++;
    if (o_cpu_rvalid !== 1'b1 || o_cpu_rdata !== init_word(10'h041)) begin
      n_fail++;
      $display("FAIL starve_cpu_return: got rvalid=%b data=%h, expected 1 %h",
               o_cpu_rvalid, o_cpu_rdata, init_word(10'h041));
    end
    idle(1);
  endtask

  task automatic test_simultaneous();
    // c: cycle index, expected winner 1=cpu 0=lcd; lcd drops on cycle 1 only
    bit exp_cpu [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cpu_we = 1'b0; cpu_addr = 10'h050; lcd_addr = 10'h051;
    for (int c = 0; c < 7; c++) begin
      cpu_req = 1'b1;
      lcd_req = (c != 1);
      cycle();
      n_checks++;
      if (o_cpu_ready !== exp_cpu[c] || o_lcd_ready !== !exp_cpu[c]) begin
        n_fail++;
        $display("FAIL simultaneous c=%0d: got cpu=%b lcd=%b, expected cpu=%b",
                 c, o_cpu_ready, o_lcd_ready, exp_cpu[c]);
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_read();
    lcd_req = 1'b1; lcd_addr = 10'h015;
    cycle();
    n_checks++;
    if (o_lcd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_grant: got lcd_ready=%b, expected 1", o_lcd_ready);
    end
    sys_rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_wstrb = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if ({o_cpu_ready, o_lcd_ready, o_mem_en, o_cpu_rvalid, o_lcd_rvalid, o_mem_we} !== 13'h0) begin
        n_fail++;
        $display("FAIL midrst_during i=%0d: got rdy=%b/%b en=%b rv=%b/%b we=%h, expected all 0",
                 i, o_cpu_ready, o_lcd_ready, o_mem_en, o_cpu_rvalid, o_lcd_rvalid, o_mem_we);
      end
    end
    sys_rst = 1'b1; cpu_req = 1'b0; lcd_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if ({o_cpu_ready, o_lcd_ready, o_mem_en, o_cpu_rvalid, o_lcd_rvalid, o_mem_we} !== 13'h0) begin
        n_fail++;
        $display("FAIL midrst_after i=%0d: got rdy=%b/%b en=%b rv=%b/%b we=%h, expected all 0",
                 i, o_cpu_ready, o_lcd_ready, o_mem_en, o_cpu_rvalid, o_lcd_rvalid, o_mem_we);
      end
    end
  endtask

  task automatic test_zero_strobe();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h055;
    cpu_wdata = 64'hFFFF_FFFF_FFFF_FFFF; cpu_wstrb = 8'h00;
    cycle();
    n_checks++;
    if (o_cpu_ready !== 1'b1 || o_mem_en !== 1'b1 || o_mem_we !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_strobe_grant: got ready=%b en=%b we=%h, expected 1 1 00",
               o_cpu_ready, o_mem_en, o_mem_we);
    end
    cpu_we = 1'b0;
    cycle();
    n_checks++;
    if (o_cpu_rvalid !== 1'b0 || o_cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_strobe_no_rvalid: got rvalid=%b ready=%b, expected 0 1",
               o_cpu_rvalid, o_cpu_ready);
    end
    cpu_req = 1'b0;
    cycle();
    n_checks++;
    if (o_cpu_rvalid !== 1'b1 || o_cpu_rdata !== init_word(10'h055)) begin
      n_fail++;
      $display("FAIL zero_strobe_unchanged: got rvalid=%b data=%h, expected 1 %h",
               o_cpu_rvalid, o_cpu_rdata, init_word(10'h055));
    end
    idle(1);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] e_addr;
    for (int n = 0; n < 400; n++) begin
      // Requesters hold their request until it is accepted
      if (!cpu_req || o_cpu_ready) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 10'h100 + 10'($urandom_range(0, 7));
        cpu_wdata = {$urandom, $urandom};
        cpu_wstrb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      end
      if (!lcd_req || o_lcd_ready) begin
        lcd_req  = ($urandom_range(0, 1) != 0);
        lcd_addr = 10'h100 + 10'($urandom_range(0, 15));
      end
      sys_rst = ($urandom_range(0, 63) != 0);
      cycle();
      e_addr = e_gl ? lcd_addr : (e_gc ? cpu_addr : 10'h000);
      n_checks++;
      if (o_lcd_ready !== e_gl || o_cpu_ready !== e_gc || o_mem_en !== (e_gl | e_gc)) begin
        n_fail++;
        $display("FAIL rnd_grant n=%0d: got lcd=%b cpu=%b en=%b, expected %b %b %b",
                 n, o_lcd_ready, o_cpu_ready, o_mem_en, e_gl, e_gc, e_gl | e_gc);
      end
      n_checks++;
      if (o_mem_addr !== e_addr || o_mem_we !== ((e_gc && cpu_we) ? cpu_wstrb : 8'h00)) begin
        n_fail++;
        $display("FAIL rnd_mem n=%0d: got addr=%h we=%h, expected %h %h",
                 n, o_mem_addr, o_mem_we, e_addr, (e_gc && cpu_we) ? cpu_wstrb : 8'h00);
      end
      if (e_gc && cpu_we) begin
        n_checks++;
        if (o_mem_wdata !== cpu_wdata) begin
          n_fail++;
          $display("FAIL rnd_wdata n=%0d: got %h expected %h", n, o_mem_wdata, cpu_wdata);
        end
      end
      n_checks++;
      if (o_cpu_rvalid !== e_crv || o_lcd_rvalid !== e_lrv) begin
        n_fail++;
        $display("FAIL rnd_rvalid n=%0d: got cpu=%b lcd=%b, expected %b %b",
                 n, o_cpu_rvalid, o_lcd_rvalid, e_crv, e_lrv);
      end
      if (e_crv || e_lrv) begin
        n_checks++;
        if ((e_crv ? o_cpu_rdata : o_lcd_rdata) !== e_rdata) begin
          n_fail++;
          $display("FAIL rnd_rdata n=%0d: got %h expected %h",
                   n, e_crv ? o_cpu_rdata : o_lcd_rdata, e_rdata);
        end
      end
    end
    sys_rst = 1'b1;
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    mem_rdata = 64'h0;
    losses = 0; pend = 0; pend_data = 64'h0;
    sys_rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'h000;
    cpu_wdata = 64'h0; cpu_wstrb = 8'h00; lcd_req = 1'b0; lcd_addr = 10'h000;
    test_reset();
    test_lcd_burst();
    test_partial_write();
    test_starvation();
    test_simultaneous();
    test_reset_mid_read();
    test_zero_strobe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/vmem_arbiter.md
VMEM_ARBITER -- requirements
Module: vmem_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, video-memory word address width (64-bit words).
REQ-002 SHALL provide parameter STARVE_MAX, default 4, number of consecutive CPU losses that forces a CPU grant (range 1..15).
REQ-003 SHALL provide port sys_clk input 1, single clock; all state updates on the rising edge.
REQ-004 SHALL provide port sys_rst input 1, asynchronous active-low reset.
REQ-005 SHALL provide CPU ports: cpu_req in 1 (request); cpu_we in 1 (1=write, 0=read); cpu_addr in ADDR_W; cpu_wdata in 64; cpu_wstrb in 8 (byte enables); cpu_ready out 1 (request accepted this cycle); cpu_rdata out 64; cpu_rvalid out 1 (read data valid).
REQ-006 SHALL provide LCD ports: lcd_req in 1 (read request); lcd_addr in ADDR_W; lcd_ready out 1 (accepted this cycle); lcd_rdata out 64; lcd_rvalid out 1 (read data valid).
REQ-007 SHALL provide memory ports: mem_en out 1; mem_we out 8 (byte write enables); mem_addr out ADDR_W; mem_wdata out 64; mem_rdata in 64, valid exactly one cycle after a read access.

Function
REQ-008 SHALL issue at most one memory access per cycle, selected combinationally from the current requests and registered state.
REQ-009 SHALL complete a transfer in any cycle where req and ready are both 1; requesters hold req, addr, and data stable until ready.
REQ-010 SHALL give the LCD priority whenever both request, except when starve_cnt == STARVE_MAX, in which case the CPU SHALL be granted.
REQ-011 SHALL keep starve_cnt (4-bit): +1 in each cycle cpu_req=1 and the CPU is not granted; saturate at STARVE_MAX; clear to 0 on a CPU grant or when cpu_req=0.
REQ-012 On an LCD grant: mem_en=1, mem_we=0, mem_addr=lcd_addr, lcd_ready=1, cpu_ready=0.
REQ-013 On a CPU write grant: mem_en=1, mem_we=cpu_wstrb, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_ready=1; cpu_wstrb=0 SHALL still complete as a no-op write with no rvalid.
REQ-014 On a CPU read grant: mem_en=1, mem_we=0, mem_addr=cpu_addr, cpu_ready=1.
REQ-015 With no grant: mem_en=0, mem_we=0, both ready=0; mem_addr and mem_wdata don't-care (drive 0).
REQ-016 SHALL register the read owner (none/CPU/LCD) each cycle; in the next cycle assert exactly one of cpu_rvalid/lcd_rvalid for one cycle, with its rdata = mem_rdata.
REQ-017 Read latency SHALL be exactly 1 cycle from req&ready to rvalid; back-to-back grants SHALL sustain one access per cycle.
REQ-018 rdata outputs SHALL be mem_rdata unconditionally; consumers SHALL qualify with rvalid.
REQ-019 A write followed next cycle by a read to the same address SHALL return the written data; no internal forwarding is required.

Reset
REQ-020 While sys_rst=0: cpu_ready, lcd_ready, mem_en, cpu_rvalid, lcd_rvalid = 0; mem_we = 8'h00; starve_cnt = 0; read owner = none.
REQ-021 Reset asserted mid-operation SHALL discard any pending read return; no rvalid SHALL appear in the first cycle after deassertion.
REQ-022 The first grant after reset release SHALL occur in the first rising edge with sys_rst=1 and a request present.

Verification
REQ-023 LCD-only reads of addr 0x010..0x013 on 4 consecutive cycles -> lcd_ready=1 each cycle; lcd_rvalid=1 for 4 cycles, each 1 cycle later, with the matching memory words.
REQ-024 CPU write 0x3FF, data 64'h1122334455667788, wstrb 8'h0F, then read 0x3FF -> upper 4 bytes retain their previous value; lower bytes = 0x55667788; cpu_rvalid 1 cycle after the read grant.
REQ-025 lcd_req and cpu_req held continuously, STARVE_MAX=4 -> LCD granted 4 cycles, CPU 5th, then repeats (pattern L,L,L,L,C); starve_cnt never exceeds 4.
REQ-026 Simultaneous first requests with starve_cnt=0 -> LCD granted; CPU granted in the first cycle lcd_req=0; starve_cnt cleared on that grant.
REQ-027 sys_rst pulled low in the cycle after an LCD read grant -> lcd_rvalid stays 0 and all outputs take their REQ-020 values during reset and after release.
REQ-028 CPU write with wstrb=0 -> cpu_ready=1, mem_en=1, mem_we=0, no cpu_rvalid; memory unchanged.
